// File: rtl/fnn_image_feeder_pkg.sv
// Shared constants, defaults and state encoding for the FNN image feeder.
package fnn_image_feeder_pkg;

    localparam int unsigned DEF_INDATA_WIDTH = 16;
    localparam int unsigned DEF_NO_INPUTS    = 784;
    localparam int unsigned DEF_ADDR_WIDTH   = 10;
    localparam int unsigned CLASS_WIDTH      = 4;
    localparam int unsigned STATE_WIDTH      = 3;

    localparam logic [STATE_WIDTH-1:0] ST_FILL     = 3'd0;
    localparam logic [STATE_WIDTH-1:0] ST_ARM      = 3'd1;
    localparam logic [STATE_WIDTH-1:0] ST_STREAM   = 3'd2;
    localparam logic [STATE_WIDTH-1:0] ST_WAIT_RES = 3'd3;
    localparam logic [STATE_WIDTH-1:0] ST_RESTART  = 3'd4;

    typedef enum logic [STATE_WIDTH-1:0] {
        FILL     = ST_FILL,
        ARM      = ST_ARM,
        STREAM   = ST_STREAM,
        WAIT_RES = ST_WAIT_RES,
        RESTART  = ST_RESTART
    } state_e;

endpackage

// File: rtl/fnn_image_buffer.sv
// Image buffer: one write port, one registered read port, contents not reset.
module fnn_image_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 784,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fnn_image_feeder.sv
// Buffers one image from a valid/ready source, streams it to the FNN controller
// and collects the predicted class. FNN_FEEDER_PINGPONG_EN enables a second bank.
module fnn_image_feeder
    import fnn_image_feeder_pkg::*;
#(
    parameter int unsigned INDATA_WIDTH = DEF_INDATA_WIDTH,
    parameter int unsigned NO_INPUTS    = DEF_NO_INPUTS,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INDATA_WIDTH-1:0] pix_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic                    start_FNN,
    output logic                    ready_in,
    output logic                    restart,
    output logic [INDATA_WIDTH-1:0] input_image,
    input  logic                    FNN_ready_to_accept,
    input  logic                    finish_FNN,
    input  logic [CLASS_WIDTH-1:0]  max,
    output logic [CLASS_WIDTH-1:0]  result_class,
    output logic                    result_valid,
    output logic                    busy
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] N_PIX = PTR_W'(NO_INPUTS);

    state_e state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic inflight_q, inflight_d;
    logic rearm_q, rearm_d;
    logic pix_ready_q, pix_ready_d;
    logic start_q, start_d;
    logic ready_in_q, ready_in_d;
    logic restart_q, restart_d;
    logic busy_q, busy_d;
    logic result_valid_q, result_valid_d;
    logic [CLASS_WIDTH-1:0]  class_q, class_d;
    logic [INDATA_WIDTH-1:0] image_q, image_d;
    logic [INDATA_WIDTH-1:0] rd_data;
    logic xfer, fill_full, stale, arm_new, rd_en;

    assign xfer       = pix_valid & pix_ready_q;
    assign wr_ptr_nxt = wr_ptr_q + PTR_W'(xfer);
    assign fill_full  = (wr_ptr_nxt == N_PIX);
    // A finish before the controller has taken an image belongs to an older run.
    assign stale      = finish_FNN & ~inflight_q;
    assign rd_en      = (rd_ptr_d < N_PIX);

`ifdef FNN_FEEDER_PINGPONG_EN
    logic wr_bank_q, wr_bank_d;
    logic [INDATA_WIDTH-1:0] rd_data0, rd_data1;

    fnn_image_buffer #(
        .DATA_WIDTH (INDATA_WIDTH),
        .DEPTH      (NO_INPUTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank0 (
        .clk       (clk),
        .wr_en_i   (xfer & ~wr_bank_q),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (pix_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_d[ADDR_WIDTH-1:0]),
        .rd_data_o (rd_data0)
    );

    fnn_image_buffer #(
        .DATA_WIDTH (INDATA_WIDTH),
        .DEPTH      (NO_INPUTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank1 (
        .clk       (clk),
        .wr_en_i   (xfer & wr_bank_q),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (pix_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_d[ADDR_WIDTH-1:0]),
        .rd_data_o (rd_data1)
    );

    // The stream bank is always the one not being filled.
    assign rd_data = wr_bank_q ? rd_data0 : rd_data1;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
        end
    end
`else
    fnn_image_buffer #(
        .DATA_WIDTH (INDATA_WIDTH),
        .DEPTH      (NO_INPUTS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank0 (
        .clk       (clk),
        .wr_en_i   (xfer),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (pix_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_d[ADDR_WIDTH-1:0]),
        .rd_data_o (rd_data)
    );
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_nxt;
        rd_ptr_d       = rd_ptr_q;
        inflight_d     = inflight_q;
        rearm_d        = rearm_q;
        image_d        = '0;
        class_d        = class_q;
        result_valid_d = 1'b0;
        arm_new        = 1'b0;
`ifdef FNN_FEEDER_PINGPONG_EN
        wr_bank_d      = wr_bank_q;
`endif

        case (state_q)
            FILL: begin
                if (stale) begin
                    state_d = RESTART;
                end else if (fill_full) begin
                    state_d = ARM;
                    arm_new = 1'b1;
                end
            end
            ARM: begin
                if (stale) begin
                    state_d = RESTART;
                    rearm_d = 1'b1;
                end else if (FNN_ready_to_accept) begin
                    // The read register already holds pixel 0; fetch pixel 1 now.
                    state_d    = STREAM;
                    image_d    = rd_data;
                    rd_ptr_d   = PTR_W'(1);
                    inflight_d = 1'b1;
`ifndef FNN_FEEDER_PINGPONG_EN
                    wr_ptr_d   = '0;
`endif
                end
            end
            STREAM: begin
                if (rd_ptr_q == N_PIX) begin
                    state_d  = WAIT_RES;
                    rd_ptr_d = '0;
                end else begin
                    image_d  = rd_data;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end
            WAIT_RES: begin
                if (finish_FNN) begin
                    state_d        = RESTART;
                    class_d        = max;
                    result_valid_d = inflight_q;
                    inflight_d     = 1'b0;
                end
            end
            RESTART: begin
                if (!finish_FNN) begin
                    if (rearm_q) begin
                        state_d = ARM;
                        rearm_d = 1'b0;
                    end else if (fill_full) begin
                        state_d = ARM;
                        arm_new = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

`ifdef FNN_FEEDER_PINGPONG_EN
        if (arm_new) begin
            wr_bank_d = ~wr_bank_q;
            wr_ptr_d  = '0;
        end
        pix_ready_d = (wr_ptr_d < N_PIX);
`else
        pix_ready_d = (state_d == FILL) && (wr_ptr_d < N_PIX);
`endif
        start_d    = (state_d == ARM) || (state_d == STREAM);
        ready_in_d = start_d;
        restart_d  = (state_d == RESTART);
        busy_d     = (state_d != FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FILL;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_q     <= 1'b0;
            rearm_q        <= 1'b0;
            pix_ready_q    <= 1'b0;
            start_q        <= 1'b0;
            ready_in_q     <= 1'b0;
            restart_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            class_q        <= '0;
            image_q        <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= inflight_d;
            rearm_q        <= rearm_d;
            pix_ready_q    <= pix_ready_d;
            start_q        <= start_d;
            ready_in_q     <= ready_in_d;
            restart_q      <= restart_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            class_q        <= class_d;
            image_q        <= image_d;
        end
    end

    assign pix_ready    = pix_ready_q;
    assign start_FNN    = start_q;
    assign ready_in     = ready_in_q;
    assign restart      = restart_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_class = class_q;
    assign input_image  = image_q;

endmodule

// File: tb/tb_fnn_image_feeder.sv
// Directed bench for fnn_image_feeder (single-bank build).
module tb_fnn_image_feeder;

    localparam int NPIX = 784;

    logic        clk;
    logic        reset;
    logic [15:0] pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        start_FNN;
    logic        ready_in;
    logic        restart;
    logic [15:0] input_image;
    logic        FNN_ready_to_accept;
    logic        finish_FNN;
    logic [3:0]  max_cls;
    logic [3:0]  result_class;
    logic        result_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fnn_image_feeder dut (
        .clk                 (clk),
        .reset               (reset),
        .pix_in              (pix_in),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready),
        .start_FNN           (start_FNN),
        .ready_in            (ready_in),
        .restart             (restart),
        .input_image         (input_image),
        .FNN_ready_to_accept (FNN_ready_to_accept),
        .finish_FNN          (finish_FNN),
        .max                 (max_cls),
        .result_class        (result_class),
        .result_valid        (result_valid),
        .busy                (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pix_val(input int pat, input int k);
        case (pat)
            0:       return 16'(k);
            1:       return 16'(NPIX - k);
            default: return 16'(k * 37 + 5) ^ 16'hA5A5;
        endcase
    endfunction

    task automatic check_reset_state();
        check("rst_pix_ready",    pix_ready,    0);
        check("rst_start_FNN",    start_FNN,    0);
        check("rst_ready_in",     ready_in,     0);
        check("rst_restart",      restart,      0);
        check("rst_input_image",  input_image,  0);
        check("rst_result_class", result_class, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy",         busy,         0);
    endtask

    // Push pixels [from, to) of pattern pat; gappy drops pix_valid every other cycle.
    task automatic fill_image(input int pat, input int from, input int to, input bit gappy);
        int k;
        int cyc;
        int bad;
        bit xfer;
        k = from;
        cyc = 0;
        bad = 0;
        while (k < to && cyc < 4 * NPIX) begin
            pix_valid = gappy ? ((cyc % 2) == 0) : 1'b1;
            pix_in = pix_val(pat, k);
            if (start_FNN !== 1'b0 || ready_in !== 1'b0 || restart !== 1'b0 ||
                input_image !== 16'd0 || busy !== 1'b0) bad++;
            if (k > from && pix_ready !== 1'b1) bad++;
            xfer = (pix_valid === 1'b1) && (pix_ready === 1'b1);
            tick();
            if (xfer) k++;
            cyc++;
        end
        pix_valid = 1'b0;
        check("fill_count", k, to);
        check("fill_phase_outputs", bad, 0);
        if (to == NPIX) begin
            check("arm_pix_ready", pix_ready, 0);
            check("arm_start_FNN", start_FNN, 1);
            check("arm_ready_in",  ready_in,  1);
            check("arm_busy",      busy,      1);
        end
    endtask

    // Hold ARM for delay cycles, then accept and check n_chk streamed pixels.
    task automatic stream_image(input int pat, input int delay, input int n_chk);
        int bad;
        bad = 0;
        for (int i = 0; i < delay; i++) begin
            if (start_FNN !== 1'b1 || ready_in !== 1'b1 || input_image !== 16'd0 ||
                restart !== 1'b0) bad++;
            tick();
        end
        FNN_ready_to_accept = 1'b1;
        tick();
        FNN_ready_to_accept = 1'b0;
        for (int k = 0; k < n_chk; k++) begin
            if (input_image !== pix_val(pat, k) || start_FNN !== 1'b1 ||
                ready_in !== 1'b1 || restart !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        check("stream_pixels", bad, 0);
        if (n_chk == NPIX) begin
            check("post_stream_image",   input_image, 0);
            check("post_stream_start",   start_FNN,   0);
            check("post_stream_readyin", ready_in,    0);
            check("post_stream_busy",    busy,        1);
        end
    endtask

    task automatic result_phase(input logic [3:0] cls, input int hold);
        int bad;
        tick();
        check("wait_restart", restart, 0);
        check("wait_valid", result_valid, 0);
        finish_FNN = 1'b1;
        max_cls = cls;
        tick();
        check("result_valid", result_valid, 1);
        check("result_class", result_class, 32'(cls));
        check("restart_on", restart, 1);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (result_valid !== 1'b0 || restart !== 1'b1 || pix_ready !== 1'b0) bad++;
        end
        check("restart_hold", bad, 0);
        finish_FNN = 1'b0;
        max_cls = 4'd0;
        tick();
        check("restart_off", restart, 0);
        check("refill_ready", pix_ready, 1);
        check("refill_busy", busy, 0);
        check("class_kept", result_class, 32'(cls));
    endtask

    initial begin
        reset = 1'b1;
        pix_in = '0;
        pix_valid = 1'b0;
        FNN_ready_to_accept = 1'b0;
        finish_FNN = 1'b0;
        max_cls = '0;
        tick();
        tick();
        check_reset_state();
        reset = 1'b0;

        // Gapless ascending image, delayed accept, class 7 with finish held 3 cycles.
        fill_image(0, 0, NPIX, 1'b0);
        stream_image(0, 3, NPIX);
        result_phase(4'd7, 3);

        // 50% valid, descending values, accept already high during fill.
        FNN_ready_to_accept = 1'b1;
        fill_image(1, 0, NPIX, 1'b1);
        stream_image(1, 0, NPIX);
        result_phase(4'd9, 1);

        // Reset at pixel 300 of the stream.
        fill_image(2, 0, NPIX, 1'b0);
        stream_image(2, 0, 300);
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0;

        // Late finish from the aborted run arrives together with pixel 100.
        fill_image(2, 0, 100, 1'b0);
        pix_valid = 1'b1;
        pix_in = pix_val(2, 100);
        finish_FNN = 1'b1;
        max_cls = 4'd3;
        tick();
        pix_valid = 1'b0;
        check("stale_restart", restart, 1);
        check("stale_no_valid", result_valid, 0);
        check("stale_class", result_class, 0);
        check("stale_pix_ready", pix_ready, 0);
        tick();
        tick();
        check("stale_restart_held", restart, 1);
        check("stale_still_no_valid", result_valid, 0);
        finish_FNN = 1'b0;
        max_cls = 4'd0;
        tick();
        check("stale_restart_off", restart, 0);
        check("stale_refill_ready", pix_ready, 1);
        check("stale_no_start", start_FNN, 0);

        // Pixels 0..100 are kept; complete the image and run it normally.
        fill_image(2, 101, NPIX, 1'b0);
        stream_image(2, 1, NPIX);
        result_phase(4'd12, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fnn_image_feeder.md
Name: fnn_image_feeder

Overview:
- Upstream stage of the FNN controller. Collects one 784-pixel image from a valid/ready pixel source into a local image buffer.
- Once the image is complete, it launches an inference and streams the pixels contiguously, one per clock, on the controller's input_image bus. The controller has no backpressure, so the whole image must be buffered before launch.
- Captures the 4-bit predicted class, then issues the controller's restart handshake and returns to filling.

Parameters:
- INDATA_WIDTH, 16, pixel width; matches controller input_image.
- NO_INPUTS, 784, pixels per image.
- ADDR_WIDTH, 10, buffer address width; must satisfy 2^ADDR_WIDTH >= NO_INPUTS.

Ports:
- clk  in  1  single clock; block logic on posedge.
- reset  in  1  synchronous, active-high.
- pix_in  in  INDATA_WIDTH  source pixel.
- pix_valid  in  1  source pixel valid.
- pix_ready  out  1  feeder accepts pixel (transfer = valid && ready).
- start_FNN  out  1  inference request to controller.
- ready_in  out  1  image available to controller.
- restart  out  1  controller restart request.
- input_image  out  INDATA_WIDTH  pixel stream to controller.
- FNN_ready_to_accept  in  1  controller is about to sample pixels.
- finish_FNN  in  1  controller result valid (level).
- max  in  4  controller predicted class.
- result_class  out  4  captured class.
- result_valid  out  1  one-cycle pulse when result_class updates.
- busy  out  1  high in any state except FILL.

Behaviour:
- Reset values:
  - Outputs: pix_ready=0, start_FNN=0, ready_in=0, restart=0, input_image=0, result_class=0, result_valid=0, busy=0.
  - State: FILL, wr_ptr=0, rd_ptr=0, inflight=0.
- Buffer: NO_INPUTS x INDATA_WIDTH, single write port, single read port, inferred RAM, no reset on contents.
- FILL:
  - pix_ready=1 while wr_ptr<NO_INPUTS.
  - Each transfer writes buf[wr_ptr] and increments wr_ptr.
  - When the transfer at wr_ptr==NO_INPUTS-1 completes, the next cycle goes to ARM with pix_ready=0. No further pixels are accepted.
- ARM:
  - start_FNN=1, ready_in=1, inflight=1, rd_ptr=0.
  - On the first posedge sampling FNN_ready_to_accept=1, go to STREAM.
- STREAM:
  - After that posedge (call it t), input_image=buf[0]. During cycle t+k, input_image=buf[k] for k=0..NO_INPUTS-1.
  - The controller samples on the negedge inside each cycle.
  - Read data must be registered so buf[0] is valid in cycle t; prefetch buf[0] in ARM.
  - After the last pixel: input_image=0, start_FNN=0, ready_in=0, go to WAIT_RES.
  - FNN_ready_to_accept deasserting mid-stream does not stall the stream.
- WAIT_RES:
  - When finish_FNN=1, latch result_class=max.
  - Pulse result_valid only if inflight=1; clear inflight; go to RESTART.
- RESTART:
  - Hold restart=1 until finish_FNN samples 0.
  - Then restart=0, wr_ptr=0, go to FILL.
  - restart must be 0 in ARM and STREAM, because the controller observes it during pixel intake.
- finish_FNN=1 observed in FILL or ARM with inflight=0 (stale inference, e.g. after a mid-run reset): go to RESTART without result_valid. In FILL, the pixels already captured are kept.
- Reset mid-operation: the feeder reverts to the reset state. The controller is not reset by this block; its late finish_FNN is discarded via the stale rule above.
- Simultaneous pix_valid and a stale finish_FNN in FILL: the pixel is accepted this cycle, then RESTART.

Optional Feature:
- Macro FNN_FEEDER_PINGPONG_EN.
- Defined:
  - Two image banks. FILL into the idle bank continues while the other bank is in ARM/STREAM/WAIT_RES/RESTART. pix_ready=1 whenever the fill bank is not full.
  - The next ARM starts from RESTART exit directly if the fill bank is full; banks swap at ARM entry.
  - busy reflects the inference path only.
- Undefined: single bank; pix_ready=0 outside FILL, exactly as above.

Decomposition:
- Shared package holds:
  - localparams for state encoding (FILL, ARM, STREAM, WAIT_RES, RESTART).
  - Default NO_INPUTS/INDATA_WIDTH.
  - The class-width constant (4).
- One sub-module: fnn_image_buffer (parameterised dual-port RAM with registered read; instantiated twice under FNN_FEEDER_PINGPONG_EN).

Test Plan:
- Fill 784 pixels pix[k]=k with pix_valid always 1. Expect: pix_ready falls after the 784th transfer; start_FNN=ready_in=1 next cycle; after FNN_ready_to_accept rises at cycle t, input_image=k in cycle t+k; input_image=0 from t+784.
- Source with pix_valid toggling 50% and value pix[k]=784-k. Expect: buffer order preserved; stream identical to the gapless case.
- Model returns finish_FNN=1 with max=7 and holds it for 3 cycles after restart. Expect: result_class=7; result_valid high exactly one cycle; restart high until finish_FNN=0; then pix_ready=1.
- Assert reset in STREAM at pixel 300, then model raises finish_FNN with max=3. Expect: no result_valid; restart handshake runs; a later full image yields a normal result.
- Check restart and FNN_ready_to_accept interaction. Expect: restart never 1 while in ARM/STREAM; start_FNN=0 in FILL.
- With FNN_FEEDER_PINGPONG_EN, a second image is sent during the first inference. Expect: pix_ready stays 1 during STREAM; the second ARM follows RESTART with zero FILL cycles; both results are correct in order.
